// File: rtl/bdd_eval_engine.sv
// bdd_eval_engine
//   Sequential, table-driven BDD evaluator. A node table holds the BDDs for
//   N_OUT output bits and a root table holds one root pointer per output.
//   For each accepted input vector the engine walks one node per cycle, one
//   output after another, and returns the full output vector.
//
//   Pointer encoding: 0 = terminal 0, 1 = terminal 1, >=2 = node (ptr-2).
//   Node word: {var[VAR_W-1:0], hi[PTR_W-1:0], lo[PTR_W-1:0]}.
//
//   Optional feature macro: BDD_COMPLEMENT_EN
//     When defined, the MSB of every lo/hi/root pointer is a complement flag.
//     Flags XOR-accumulate along the walk and the terminal value is XORed
//     with the accumulated parity. PTR_W grows by one bit.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   node_we/addr/wdata        node-table write port (accepted only in IDLE)
//   root_we/addr/wdata        root-table write port (accepted only in IDLE)
//   in_valid/in_ready/i       input vector handshake
//   out_valid/out_ready/o     result vector handshake
//   err                       sticky overflow / out-of-range flag, valid with out_valid
module bdd_eval_engine #(
    parameter int IN_W       = 1894,
    parameter int N_OUT      = 128,
    parameter int NODE_DEPTH = 1024,
    parameter int MAX_STEPS  = 64,
    localparam int AW        = $clog2(NODE_DEPTH),
    localparam int BASE_W    = AW + 1,
`ifdef BDD_COMPLEMENT_EN
    localparam int PTR_W     = BASE_W + 1,
`else
    localparam int PTR_W     = BASE_W,
`endif
    localparam int VAR_W     = $clog2(IN_W),
    localparam int NODE_W    = VAR_W + 2 * PTR_W,
    localparam int OW        = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              node_we,
    input  logic [AW-1:0]     node_addr,
    input  logic [NODE_W-1:0] node_wdata,
    input  logic              root_we,
    input  logic [OW-1:0]     root_addr,
    input  logic [PTR_W-1:0]  root_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  o,
    output logic              err
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    typedef enum logic [1:0] {IDLE, WALK, NEXT, DONE} state_t;

    state_t              state;
    logic [IN_W-1:0]     i_q;
    logic [OW-1:0]       out_idx;
    logic [BASE_W-1:0]   cur;     // current pointer without complement flag
    logic                par;     // accumulated complement parity
    logic [SW-1:0]       steps;
    logic [N_OUT-1:0]    o_q;

    logic [NODE_W-1:0]   node_mem [NODE_DEPTH];
    logic [PTR_W-1:0]    root_mem [N_OUT];

    // ------------------------------------------------------------------
    // Table write port
    // ------------------------------------------------------------------
    // NOTE: the tables carry no reset; they hold a trained model that must
    // survive a reset, and leaving them unreset keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (state == IDLE && node_we)
            node_mem[node_addr] <= node_wdata;
        if (state == IDLE && root_we)
            root_mem[root_addr] <= root_wdata;
    end

    // ------------------------------------------------------------------
    // Asynchronous table reads and next-pointer selection
    // ------------------------------------------------------------------
    logic [BASE_W-1:0] node_idx;
    logic              node_in_range;
    logic [NODE_W-1:0] node_word;
    logic [VAR_W-1:0]  node_var;
    logic [PTR_W-1:0]  node_hi, node_lo, nxt;
    logic              sel_bit;
    logic [OW-1:0]     root_rd_addr;
    logic [PTR_W-1:0]  root_word;
    logic              nxt_flag, root_flag;

    assign node_idx      = cur - BASE_W'(2);
    assign node_in_range = 32'(node_idx) < 32'(NODE_DEPTH);
    assign node_word     = node_mem[node_idx[AW-1:0]];
    assign node_var      = node_word[NODE_W-1 -: VAR_W];
    assign node_hi       = node_word[2*PTR_W-1 -: PTR_W];
    assign node_lo       = node_word[PTR_W-1:0];
    // Variable indices beyond the input width read as 0.
    assign sel_bit       = (32'(node_var) < 32'(IN_W)) ? i_q[node_var] : 1'b0;
    assign nxt           = sel_bit ? node_hi : node_lo;

    // IDLE fetches output 0's root; NEXT fetches the following output's root.
    assign root_rd_addr  = (state == IDLE) ? '0 : out_idx + OW'(1);
    assign root_word     = root_mem[root_rd_addr];

`ifdef BDD_COMPLEMENT_EN
    assign nxt_flag  = nxt[PTR_W-1];
    assign root_flag = root_word[PTR_W-1];
`else
    assign nxt_flag  = 1'b0;
    assign root_flag = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ------------------------------------------------------------------
    // NOTE: every state element here uses non-blocking assignment so all
    // registers update together from the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            o         <= '0;
            err       <= 1'b0;
            out_idx   <= '0;
            cur       <= '0;
            par       <= 1'b0;
            steps     <= '0;
            o_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        i_q      <= i;
                        out_idx  <= '0;
                        cur      <= root_word[BASE_W-1:0];
                        par      <= root_flag;
                        steps    <= '0;
                        in_ready <= 1'b0;
                        state    <= WALK;
                    end
                end
                WALK: begin
                    if (cur < BASE_W'(2)) begin
                        o_q[out_idx] <= cur[0] ^ par;
                        state        <= NEXT;
                    end else if (!node_in_range || steps == SW'(MAX_STEPS)) begin
                        // Dangling pointer or runaway walk: force 0 and flag it.
                        o_q[out_idx] <= 1'b0;
                        err          <= 1'b1;
                        state        <= NEXT;
                    end else begin
                        cur   <= nxt[BASE_W-1:0];
                        par   <= par ^ nxt_flag;
                        steps <= steps + SW'(1);
                    end
                end
                NEXT: begin
                    if (out_idx == OW'(N_OUT - 1)) begin
                        state <= DONE;
                    end else begin
                        out_idx <= out_idx + OW'(1);
                        cur     <= root_word[BASE_W-1:0];
                        par     <= root_flag;
                        steps   <= '0;
                        state   <= WALK;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles
                    // wait for the consumer.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        o         <= o_q;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        err       <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdd_eval_engine.sv
// tb_bdd_eval_engine
//   Scoreboard bench for bdd_eval_engine. The driver computes each expected
//   result from a table-walk reference model and queues it; a monitor pops
//   and compares whenever a new result is presented.
module tb_bdd_eval_engine;

    localparam int IN_W       = 1894;
    localparam int N_OUT      = 4;
    localparam int NODE_DEPTH = 16;
    localparam int MAX_STEPS  = 64;
    localparam int AW         = $clog2(NODE_DEPTH);
    localparam int BASE_W     = AW + 1;
`ifdef BDD_COMPLEMENT_EN
    localparam int PTR_W      = BASE_W + 1;
`else
    localparam int PTR_W      = BASE_W;
`endif
    localparam int VAR_W      = $clog2(IN_W);
    localparam int NODE_W     = VAR_W + 2 * PTR_W;
    localparam int OW         = $clog2(N_OUT);
    localparam int BASE_MASK  = (1 << BASE_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              node_we;
    logic [AW-1:0]     node_addr;
    logic [NODE_W-1:0] node_wdata;
    logic              root_we;
    logic [OW-1:0]     root_addr;
    logic [PTR_W-1:0]  root_wdata;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   i_vec;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  o;
    logic              err;

    bdd_eval_engine #(
        .IN_W(IN_W), .N_OUT(N_OUT), .NODE_DEPTH(NODE_DEPTH), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk(clk), .rst(rst),
        .node_we(node_we), .node_addr(node_addr), .node_wdata(node_wdata),
        .root_we(root_we), .root_addr(root_addr), .root_wdata(root_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .i(i_vec),
        .out_valid(out_valid), .out_ready(out_ready), .o(o), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model: shadow tables and a straightforward graph walk
    // ------------------------------------------------------------------
    int m_var  [NODE_DEPTH];
    int m_hi   [NODE_DEPTH];
    int m_lo   [NODE_DEPTH];
    int m_root [N_OUT];

    function automatic int ptr_flag(input int p);
`ifdef BDD_COMPLEMENT_EN
        return (p >> BASE_W) & 1;
`else
        return 0 * p;
`endif
    endfunction

    // Walks output k for vector v; returns the bit, the error flag and the
    // number of node visits (path length).
    function automatic void model_out(input int k, input logic [IN_W-1:0] v,
                                      output logic bit_o, output logic err_o,
                                      output int steps);
        int p, par, a, nx;
        logic b;
        bit done;
        p = m_root[k] & BASE_MASK;
        par = ptr_flag(m_root[k]);
        steps = 0; err_o = 1'b0; bit_o = 1'b0; done = 1'b0;
        while (!done) begin
            if (p < 2) begin
                bit_o = logic'((p % 2) ^ par);
                done = 1'b1;
            end else begin
                a = p - 2;
                if (a >= NODE_DEPTH || steps == MAX_STEPS) begin
                    bit_o = 1'b0; err_o = 1'b1; done = 1'b1;
                end else begin
                    b = (m_var[a] < IN_W) ? v[m_var[a]] : 1'b0;
                    nx = b ? m_hi[a] : m_lo[a];
                    par = par ^ ptr_flag(nx);
                    p = nx & BASE_MASK;
                    steps++;
                end
            end
        end
    endfunction

    typedef struct {
        logic [N_OUT-1:0] o;
        logic             err;
        int               lat;
        int               hs;
    } exp_t;

    exp_t sb[$];

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic             prev_ov = 1'b0;
    logic [N_OUT-1:0] last_o;
    logic             last_err;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_low_while_result", 64'(in_ready), 64'(0));
                if (!prev_ov) begin
                    check("scoreboard_nonempty", 64'(sb.size() > 0), 64'(1));
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("o", 64'(o), 64'(e.o));
                        check("err", 64'(err), 64'(e.err));
                        check("latency", 64'(cyc - e.hs), 64'(e.lat));
                    end
                    last_o = o;
                    last_err = err;
                end else begin
                    check("o_stable", 64'(o), 64'(last_o));
                    check("err_stable", 64'(err), 64'(last_err));
                end
            end
            prev_ov = out_valid;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    bit hold = 1'b0;
    bit stall_en = 1'b0;

    task automatic drive_or();
        out_ready = hold ? 1'b0 : (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    endtask

    task automatic write_node(input int a, input int vr, input int hi, input int lo);
        node_we = 1'b1;
        node_addr = AW'(a);
        node_wdata = {VAR_W'(vr), PTR_W'(hi), PTR_W'(lo)};
        m_var[a] = vr; m_hi[a] = hi; m_lo[a] = lo;
        @(negedge clk);
        node_we = 1'b0;
    endtask

    task automatic write_root(input int k, input int p);
        root_we = 1'b1;
        root_addr = OW'(k);
        root_wdata = PTR_W'(p);
        m_root[k] = p;
        @(negedge clk);
        root_we = 1'b0;
    endtask

    task automatic rand_vec(output logic [IN_W-1:0] v);
        for (int b = 0; b < IN_W; b++) v[b] = 1'($urandom_range(0, 1));
    endtask

    // Offers v; when push is set the model's expectation goes to the scoreboard.
    task automatic send(input logic [IN_W-1:0] v, input bit push);
        exp_t e;
        logic bt, er;
        int st, t;
        e.o = '0; e.err = 1'b0; e.lat = 1;
        for (int k = 0; k < N_OUT; k++) begin
            model_out(k, v, bt, er, st);
            e.o[k] = bt;
            e.err = e.err | er;
            e.lat += st + 2;
        end
        i_vec = v;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            drive_or();
            t++;
        end
        check("in_ready_wait", 64'(t < 5000), 64'(1));
        @(posedge clk);
        #1;
        e.hs = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        drive_or();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!(sb.size() == 0 && !out_valid && in_ready) && t < 5000) begin
            @(negedge clk);
            drive_or();
            t++;
        end
        check("drain", 64'(t < 5000), 64'(1));
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [IN_W-1:0] v;
        int t;
        rst = 1'b1; node_we = 1'b0; root_we = 1'b0; in_valid = 1'b0;
        node_addr = '0; node_wdata = '0; root_addr = '0; root_wdata = '0;
        i_vec = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_o", 64'(o), 64'(0));
        check("reset_err", 64'(err), 64'(0));

        // Constant-1 roots: all ones, 9-cycle latency.
        for (int k = 0; k < N_OUT; k++) write_root(k, 1);
        for (int a = 0; a < NODE_DEPTH; a++) write_node(a, 0, 0, 0);
        rand_vec(v); send(v, 1); drain();

        // Single node on i[95].
        write_node(0, 95, 1, 0);
        write_root(0, 2);
        rand_vec(v); v[95] = 1'b1; send(v, 1);
        rand_vec(v); v[95] = 1'b0; send(v, 1);
        drain();

        // Three-node AND chain on i[1722], i[1725], i[1723].
        write_node(1, 1722, 4, 0);
        write_node(2, 1725, 5, 0);
        write_node(3, 1723, 1, 0);
        write_root(0, 3);
        for (int c = 0; c < 8; c++) begin
            rand_vec(v);
            v[1722] = c[0]; v[1725] = c[1]; v[1723] = c[2];
            send(v, 1);
        end
        drain();

        // Self-loop overflow, then err clears for the next clean vector.
        write_node(4, 7, 6, 6);
        write_root(0, 6);
        rand_vec(v); send(v, 1); drain();
        write_root(0, 2);
        rand_vec(v); send(v, 1); drain();

        // Out-of-range node address and out-of-range variable index.
        write_node(5, 2000, 0, 1);
        write_root(1, 31);
        write_root(2, 7);
        rand_vec(v); send(v, 1); drain();
        write_root(1, 0);
        rand_vec(v); send(v, 1); drain();

        // Consumer stalls for 10 cycles; node writes in that window are ignored.
        hold = 1'b1;
        drive_or();
        rand_vec(v); v[95] = 1'b1; send(v, 1);
        t = 0;
        while (!out_valid && t < 1000) begin @(negedge clk); t++; end
        check("hold_out_valid_seen", 64'(out_valid), 64'(1));
        for (int c = 0; c < 10; c++) begin
            node_we = 1'b1; node_addr = '0;
            node_wdata = {VAR_W'(95), PTR_W'(0), PTR_W'(1)};
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        node_we = 1'b0;
        hold = 1'b0;
        drive_or();
        drain();
        send(v, 1);
        rand_vec(v); v[95] = 1'b0; send(v, 1);
        drain();

        // Reset during a long walk discards the vector.
        write_root(0, 6);
        rand_vec(v); send(v, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midwalk_rst_out_valid", 64'(out_valid), 64'(0));
        check("midwalk_rst_o", 64'(o), 64'(0));
        check("midwalk_rst_err", 64'(err), 64'(0));
        check("midwalk_rst_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;
        write_root(0, 2);
        rand_vec(v); send(v, 1); drain();

`ifdef BDD_COMPLEMENT_EN
        // Complemented pointer to terminal 0 reads as 1.
        write_root(0, 1 << BASE_W);
        rand_vec(v); send(v, 1); drain();
`endif

        // Random tables, random vectors, random consumer stalls.
        stall_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < NODE_DEPTH; a++) begin
                int vr, hp, lp, s;
                vr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(IN_W, 2047))
                                                 : int'($urandom_range(0, IN_W - 1));
                s = $urandom_range(0, 9);
                hp = (s < 3) ? s % 2 : int'($urandom_range(2, (s == 9) ? BASE_MASK : NODE_DEPTH + 1));
                s = $urandom_range(0, 9);
                lp = (s < 3) ? s % 2 : int'($urandom_range(2, (s == 9) ? BASE_MASK : NODE_DEPTH + 1));
`ifdef BDD_COMPLEMENT_EN
                hp = hp | (int'($urandom_range(0, 1)) << BASE_W);
                lp = lp | (int'($urandom_range(0, 1)) << BASE_W);
`endif
                write_node(a, vr, hp, lp);
            end
            for (int k = 0; k < N_OUT; k++)
                write_root(k, int'($urandom_range(0, (1 << PTR_W) - 1)));
            for (int n = 0; n < 8; n++) begin
                rand_vec(v);
                send(v, 1);
            end
            drain();
        end
        stall_en = 1'b0;
        drive_or();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
